seq_decoder: RTL and testbench

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder.sv | 112 +++++++++++
 tb/tb_seq_decoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// Nucleotide sequence decoder: captures up to DEPTH 3-bit symbols, then emits
// them as ASCII characters followed by a newline over a valid/ready stream.
module seq_decoder #(
  parameter int DEPTH = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] sym_in,
  input  logic       sym_valid,
  input  logic       sym_last,
  output logic       sym_ready,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic [7:0] count,
  output logic       done,
  output logic       err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, EOL, DONE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    buf_mem [DEPTH];
  logic [AW-1:0] rd;
  logic          accept;
  logic          load_end;
  logic          emit_xfer;
  logic          emit_end;

  function automatic logic [7:0] decode(input logic [2:0] code);
    logic [7:0] ch;
    case (code)
      3'd0:    ch = 8'h2D;
      3'd1:    ch = 8'h47;
      3'd2:    ch = 8'h54;
      3'd3:    ch = 8'h41;
      3'd4:    ch = 8'h43;
      default: ch = 8'h4E;
    endcase
    return ch;
  endfunction

  assign accept    = (state == LOAD) && sym_valid;
  assign load_end  = accept && (sym_last || (count == 8'(DEPTH - 1)));
  assign emit_xfer = (state == EMIT) && char_ready;
  // rd only ever indexes captured symbols, so the last one is count-1
  assign emit_end  = emit_xfer && (8'(rd) == (count - 8'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sym_ready  = 1'b0;
    char_valid = 1'b0;
    char_out   = 8'h00;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        sym_ready = 1'b1;
        if (load_end) state_nxt = EMIT;
      end
      EMIT: begin
        char_valid = 1'b1;
        char_out   = decode(buf_mem[rd]);
        if (emit_end) state_nxt = EOL;
      end
      EOL: begin
        char_valid = 1'b1;
        char_out   = 8'h0A;
        if (char_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
      err   <= 1'b0;
      rd    <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        count <= 8'd0;
        err   <= 1'b0;
      end
      if (accept) begin
        count <= count + 8'd1;
        if (sym_in >= 3'd5) err <= 1'b1;
      end
      if (emit_xfer) rd <= emit_end ? '0 : rd + AW'(1);
    end
  end

  // Buffer contents need no reset; entries are always written before being read.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[count[AW-1:0]] <= sym_in;
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: table vectors, corner sequences and
// randomized sequences compared against a symbol-to-ASCII reference model.
module tb_seq_decoder;
  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       rst, start, sym_valid, sym_last, char_ready;
  logic [2:0] sym_in;
  logic       sym_ready, char_valid, done, err;
  logic [7:0] char_out, count;

  seq_decoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_last(sym_last), .sym_ready(sym_ready), .char_out(char_out),
    .char_valid(char_valid), .char_ready(char_ready), .count(count),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: symbol code -> ASCII
  logic [7:0] ascii_tbl [8] = '{8'h2D, 8'h47, 8'h54, 8'h41, 8'h43, 8'h4E, 8'h4E, 8'h4E};

  logic [2:0] stim[$];
  logic [7:0] exp_q[$];
  int         e_cnt;
  logic       e_err;

  task automatic build_expected();
    exp_q.delete();
    e_err = 1'b0;
    foreach (stim[i]) begin
      exp_q.push_back(ascii_tbl[stim[i]]);
      if (stim[i] >= 3'd5) e_err = 1'b1;
    end
    exp_q.push_back(8'h0A);
    e_cnt = stim.size();
  endtask

  // downstream sink: 0 always ready, 1 random, 2 stall 3 cycles on 'G', 3 never ready
  int         rdy_mode = 0;
  int         stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;
  logic [7:0] got[$];
  int         stamps[$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    logic r;
    case (rdy_mode)
      0:       r = 1'b1;
      1:       r = ($urandom_range(0, 2) != 0);
      2:       r = !(char_valid && (char_out == 8'h47) && (stall_cnt < 3));
      default: r = 1'b0;
    endcase
    if (rdy_mode == 2 && !r) stall_cnt++;
    char_ready = r;
    if (prev_stall && !rst_q) begin
      check("hold_valid", char_valid, 1);
      check("hold_char", char_out, prev_char);
    end
    prev_stall = char_valid && !char_ready;
    prev_char  = char_out;
    if (char_valid && char_ready) begin
      got.push_back(char_out);
      stamps.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic load_seq(input bit use_last, input bit noisy, input bit bubbles);
    int guard;
    got.delete();
    stamps.delete();
    done_cnt  = 0;
    stall_cnt = 0;
    @(negedge clk);
    start = 1'b1; sym_valid = 1'b0; sym_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = noisy;
    check("clr_count", count, 0);
    check("clr_err", err, 0);
    check("load_ready", sym_ready, 1);
    foreach (stim[i]) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        sym_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
      sym_in    = stim[i];
      sym_valid = 1'b1;
      sym_last  = use_last && (i == stim.size() - 1);
      guard = 0;
      while (!sym_ready && guard < 20) begin
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        checks++; errors++;
        $display("FAIL load_timeout: got sym_ready 0 expected 1 at symbol %0d", i);
      end
      @(posedge clk);
      @(negedge clk);
    end
    sym_valid = 1'b0; sym_last = 1'b0;
    check("first_valid", char_valid, 1);
    check("ready_drop", sym_ready, 0);
  endtask

  task automatic finish_seq(input bit noisy);
    int guard = 0;
    do begin
      @(negedge clk);
      start     = noisy && char_valid;
      sym_valid = noisy;
      sym_in    = 3'($urandom_range(0, 7));
      guard++;
    end while (!done && guard < 2000);
    start = 1'b0; sym_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got done 0 expected 1 after %0d cycles", guard);
    end
    check("done_cv", char_valid, 0);
    repeat (3) begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_in    = 3'($urandom_range(0, 7));
    end
    check("idle_ready", sym_ready, 0);
    @(negedge clk);
    sym_valid = 1'b0;
    check("n_chars", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("char[%0d]", i), got[i], exp_q[i]);
    check("count", count, e_cnt);
    check("err", err, e_err);
    check("done_pulses", done_cnt, 1);
    if (rdy_mode == 0 && got.size() > 0)
      check("back_to_back", stamps[stamps.size() - 1] - stamps[0], got.size() - 1);
  endtask

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][2:0]  syms;
    logic [8:0][7:0]  chars;
    logic [7:0]       cnt;
    logic             e;
    logic [1:0]       rdy;
    logic             noisy;
  } vec_t;

  function automatic vec_t mkv(input int n, input logic [23:0] s, input logic [71:0] c,
                               input int cnt, input logic e, input int rdy, input logic noisy);
    vec_t v;
    v.n = 4'(n); v.syms = s; v.chars = c; v.cnt = 8'(cnt);
    v.e = e; v.rdy = 2'(rdy); v.noisy = noisy;
    return v;
  endfunction

  vec_t tbl[6];

  initial begin
    tbl[0] = mkv(4, {12'd0, 3'd2, 3'd4, 3'd1, 3'd3},
                 {32'd0, 8'h0A, 8'h54, 8'h43, 8'h47, 8'h41}, 4, 1'b0, 0, 1'b0);
    tbl[1] = mkv(4, {12'd0, 3'd2, 3'd4, 3'd1, 3'd3},
                 {32'd0, 8'h0A, 8'h54, 8'h43, 8'h47, 8'h41}, 4, 1'b0, 2, 1'b0);
    tbl[2] = mkv(3, {15'd0, 3'd3, 3'd6, 3'd0},
                 {40'd0, 8'h0A, 8'h41, 8'h4E, 8'h2D}, 3, 1'b1, 0, 1'b0);
    tbl[3] = mkv(3, {15'd0, 3'd0, 3'd2, 3'd2},
                 {40'd0, 8'h0A, 8'h2D, 8'h54, 8'h54}, 3, 1'b0, 1, 1'b1);
    tbl[4] = mkv(1, {21'd0, 3'd7}, {56'd0, 8'h0A, 8'h4E}, 1, 1'b1, 1, 1'b0);
    tbl[5] = mkv(6, {6'd0, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd5},
                 {16'd0, 8'h0A, 8'h2D, 8'h43, 8'h41, 8'h54, 8'h47, 8'h4E}, 6, 1'b1, 1, 1'b0);

    rst = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_last = 1'b0; sym_in = 3'd0;
    char_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_out", char_out, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // sym_valid in IDLE without start is not captured
    repeat (3) begin
      @(negedge clk);
      sym_valid = 1'b1; sym_in = 3'd3;
      check("idle0_ready", sym_ready, 0);
    end
    @(negedge clk);
    sym_valid = 1'b0;
    check("idle0_count", count, 0);

    foreach (tbl[k]) begin
      stim.delete();
      exp_q.delete();
      for (int j = 0; j < int'(tbl[k].n); j++) stim.push_back(tbl[k].syms[j]);
      for (int j = 0; j <= int'(tbl[k].n); j++) exp_q.push_back(tbl[k].chars[j]);
      e_cnt    = int'(tbl[k].cnt);
      e_err    = tbl[k].e;
      rdy_mode = int'(tbl[k].rdy);
      load_seq(1'b1, tbl[k].noisy, 1'b0);
      finish_seq(tbl[k].noisy);
    end

    // full buffer without sym_last
    stim.delete();
    for (int i = 0; i < DEPTH; i++) stim.push_back(3'($urandom_range(0, 7)));
    build_expected();
    rdy_mode = 0;
    load_seq(1'b0, 1'b0, 1'b0);
    finish_seq(1'b0);

    // randomized sequences against the model
    repeat (20) begin
      bit noisy;
      stim.delete();
      repeat ($urandom_range(1, 16)) stim.push_back(3'($urandom_range(0, 7)));
      build_expected();
      rdy_mode = $urandom_range(0, 1);
      noisy    = 1'($urandom_range(0, 1));
      load_seq(1'b1, noisy, 1'b1);
      finish_seq(noisy);
    end

    // reset while stalled in EMIT
    stim.delete();
    stim.push_back(3'd6); stim.push_back(3'd1); stim.push_back(3'd2); stim.push_back(3'd4);
    rdy_mode = 3;
    load_seq(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_err", err, 1);
    check("pre_rst_cv", char_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    check("mid_rst_sym_ready", sym_ready, 0);
    check("mid_rst_char_valid", char_valid, 0);
    check("mid_rst_char_out", char_out, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    repeat (4) begin
      @(negedge clk);
      sym_valid = ~sym_valid;
      sym_in    = 3'd3;
      check("post_rst_ready", sym_ready, 0);
    end
    @(negedge clk);
    sym_valid = 1'b0;
    check("post_rst_count", count, 0);
    check("post_rst_chars", got.size(), 0);
    check("post_rst_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
